// File: rtl/obuft_pkg.sv
// Shared definitions for the tri-state output bank: state encoding and
// elaboration-time width helpers.
package obuft_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_HIZ   = 2'd1,
    ST_TURN  = 2'd2,
    ST_DRIVE = 2'd3
  } obuft_state_e;

  // Ceiling log2, used to size the shared hold/turnaround counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/obuft_bus_ctl_if.sv
// Control/status bundle of the tri-state output bank; GTS models the global
// tri-state net that overrides every driver.
interface obuft_bus_ctl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             CE;
  logic [WIDTH-1:0] I;
  logic             T;
  logic             GTS;
  logic             DRV;
  logic             BUSY;

  modport master (output CE, I, T, GTS, input DRV, BUSY);
  modport slave  (input CE, I, T, GTS, output DRV, BUSY);
endinterface

// File: rtl/obuft_turn_cnt.sv
// Loadable down-counter shared by the startup hold and the bus turnaround;
// reset loads RST_VAL and the counter saturates at zero.
module obuft_turn_cnt #(
  parameter int unsigned W       = 2,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= W'(RST_VAL);
    end else if (load) begin
      cnt <= ld_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/obuft_bus_ctl.sv
// WIDTH-bit tri-state output bank with startup hold, turnaround dead time and
// drive status. Define OBUFT_BUS_CTL_OREG_EN to register the data path.
module obuft_bus_ctl
  import obuft_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TURN    = 2,
  parameter int unsigned STARTUP = 4
) (
  input  logic              C,
  input  logic              R,
  obuft_bus_ctl_if.slave    bus,
  output tri [WIDTH-1:0]    O
);

  localparam int unsigned CNT_W   = clog2(max2(TURN, STARTUP) + 1);
  localparam int unsigned TURN_LD = (TURN > 0) ? TURN - 1 : 0;
  localparam int unsigned HOLD_LD = STARTUP - 1;

  obuft_state_e     state;
  obuft_state_e     state_nxt;
  logic             cnt_zero;
  logic             cnt_load_c;
  logic             cnt_dec_c;
  logic             en_c;
  logic             oe_n_c;
  logic [WIDTH-1:0] data;

  obuft_turn_cnt #(
    .W       (CNT_W),
    .RST_VAL (HOLD_LD)
  ) u_cnt (
    .clk    (C),
    .rst    (R),
    .load   (cnt_load_c),
    .ld_val (CNT_W'(TURN_LD)),
    .dec    (cnt_dec_c),
    .zero   (cnt_zero)
  );

  // Next state and counter control; HOLD ignores CE, the others freeze on CE=0.
  always_comb begin
    state_nxt  = state;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    case (state)
      ST_HOLD: begin
        if (cnt_zero) state_nxt = ST_HIZ;
        else          cnt_dec_c = 1'b1;
      end
      ST_HIZ: begin
        if (bus.CE && !bus.T) begin
          if (TURN == 0) begin
            state_nxt = ST_DRIVE;
          end else begin
            state_nxt  = ST_TURN;
            cnt_load_c = 1'b1;
          end
        end
      end
      ST_TURN: begin
        if (bus.CE) begin
          if (bus.T)         state_nxt = ST_HIZ;
          else if (cnt_zero) state_nxt = ST_DRIVE;
          else               cnt_dec_c = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (bus.CE && bus.T) state_nxt = ST_HIZ;
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) state <= ST_HOLD;
    else   state <= state_nxt;
  end

`ifdef OBUFT_BUS_CTL_OREG_EN
  always_ff @(posedge C) begin
    if (R)           data <= '0;
    else if (bus.CE) data <= bus.I;
  end
`else
  assign data = bus.I;
`endif

  // Release is combinational so T or GTS frees the bus without waiting for an edge.
  assign en_c     = (state == ST_DRIVE) && !bus.T && !bus.GTS;
  assign oe_n_c   = ~en_c;
  assign bus.DRV  = en_c;
  assign bus.BUSY = (state == ST_HOLD) || (state == ST_TURN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    bufif0 u_pad (O[i], data[i], oe_n_c);
  end

endmodule
